// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  // Default burst geometry, shared with the convolution engine
  localparam int N_SMP = 7;   // samples per burst
  localparam int DW    = 8;   // sample width
  localparam int IW    = 3;   // sample index width
  localparam int SW    = 11;  // sum width, never overflows for N_SMP full-scale samples

  // Collector FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STAT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/conv_stat_acc.sv
// Running sum and strict-greater max/argmax over one burst.
// Latency: results reflect a beat one cycle after it is presented with load/add.
// Backpressure: none; clr has priority over load, load over add.
module conv_stat_acc #(
  parameter int DW = conv_pkg::DW,
  parameter int IW = conv_pkg::IW,
  parameter int SW = conv_pkg::SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          add,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic [IW-1:0] idx,
  output logic [SW-1:0] sum,
  output logic [DW-1:0] max_val,
  output logic [IW-1:0] max_idx
);

  // Accumulate sum; on ties the earlier index is kept (strict compare)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      max_val <= '0;
      max_idx <= '0;
    end else if (clr) begin
      sum     <= '0;
      max_val <= '0;
      max_idx <= '0;
    end else if (load) begin
      sum     <= SW'(din);
      max_val <= din;
      max_idx <= '0;
    end else if (add) begin
      sum <= sum + SW'(din);
      if (din > max_val) begin
        max_val <= din;
        max_idx <= idx;
      end
    end
  end

endmodule

// File: rtl/conv_result_collector.sv
// Captures a gap-free N_SMP-beat burst, emits sum/max/argmax, then replays samples.
// Latency: stat_valid one cycle after the final beat; replay follows the stat handshake.
// Backpressure: stat/replay channels wait on ready; input cannot stall, so beats outside
// IDLE/FILL are dropped (pulse on drop). Optional drop_cnt under CONV_COLLECT_DROP_CNT_EN.
module conv_result_collector #(
  parameter int N_SMP = conv_pkg::N_SMP,
  parameter int DW    = conv_pkg::DW,
  parameter int IW    = conv_pkg::IW,
  parameter int SW    = conv_pkg::SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          stat_valid,
  input  logic          stat_ready,
  output logic [SW-1:0] stat_sum,
  output logic [DW-1:0] stat_max,
  output logic [IW-1:0] stat_max_idx,
  output logic          rep_valid,
  input  logic          rep_ready,
  output logic [DW-1:0] rep_data,
  output logic [IW-1:0] rep_idx,
  output logic          busy,
  output logic          err_short,
`ifdef CONV_COLLECT_DROP_CNT_EN
  output logic [15:0]   drop_cnt,
`endif
  output logic          drop
);

  import conv_pkg::*;

  localparam logic [IW-1:0] LAST = IW'(N_SMP - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] cnt, ridx;
  logic [DW-1:0] smp_buf [N_SMP];
  logic          acc_load, acc_add, acc_clr;
  logic          buf_we;
  logic [IW-1:0] buf_widx;
  logic          err_nxt, drop_nxt;
  logic [SW-1:0] acc_sum;
  logic [DW-1:0] acc_max;
  logic [IW-1:0] acc_max_idx;

  conv_stat_acc #(.DW(DW), .IW(IW), .SW(SW)) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (acc_load),
    .add     (acc_add),
    .clr     (acc_clr),
    .din     (in_data),
    .idx     (cnt),
    .sum     (acc_sum),
    .max_val (acc_max),
    .max_idx (acc_max_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, accumulator/buffer controls and pulse requests
  always_comb begin
    state_nxt = state;
    acc_load  = 1'b0;
    acc_add   = 1'b0;
    acc_clr   = 1'b0;
    buf_we    = 1'b0;
    buf_widx  = cnt;
    err_nxt   = 1'b0;
    drop_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_load  = 1'b1;
          buf_we    = 1'b1;
          buf_widx  = '0;
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (in_valid) begin
          acc_add = 1'b1;
          buf_we  = 1'b1;
          if (cnt == LAST) state_nxt = STAT;
        end else begin
          // Burst ended early: discard partial statistics
          err_nxt   = 1'b1;
          acc_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      STAT: begin
        drop_nxt = in_valid;
        if (stat_ready) state_nxt = DRAIN;
      end
      DRAIN: begin
        drop_nxt = in_valid;
        if (rep_ready && ridx == LAST) begin
          acc_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fill counter and replay index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      ridx <= '0;
    end else begin
      case (state)
        IDLE:    cnt <= in_valid ? IW'(1) : '0;
        FILL:    cnt <= (in_valid && cnt != LAST) ? cnt + IW'(1) : '0;
        STAT:    if (stat_ready) ridx <= '0;
        DRAIN:   if (rep_ready) ridx <= (ridx == LAST) ? '0 : ridx + IW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  // Sample buffer; contents are only observed while draining, so no reset
  always_ff @(posedge clk) begin
    if (buf_we) smp_buf[buf_widx] <= in_data;
  end

  // Registered one-cycle event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_short <= 1'b0;
      drop      <= 1'b0;
    end else begin
      err_short <= err_nxt;
      drop      <= drop_nxt;
    end
  end

`ifdef CONV_COLLECT_DROP_CNT_EN
  // Saturating count of dropped beats and short bursts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            drop_cnt <= '0;
    else if ((err_nxt || drop_nxt) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

  // Channel outputs decode the state register; data is zero outside its phase
  assign busy         = (state != IDLE);
  assign stat_valid   = (state == STAT);
  assign rep_valid    = (state == DRAIN);
  assign stat_sum     = stat_valid ? acc_sum     : '0;
  assign stat_max     = stat_valid ? acc_max     : '0;
  assign stat_max_idx = stat_valid ? acc_max_idx : '0;
  assign rep_data     = rep_valid  ? smp_buf[ridx] : '0;
  assign rep_idx      = rep_valid  ? ridx          : '0;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector with a burst-level reference model.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// The model tracks collected samples, pending statistics and the replay pointer.
module tb_conv_result_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        stat_ready = 1'b0;
  logic        rep_ready = 1'b0;
  logic        stat_valid, rep_valid, busy, err_short, drop;
  logic [10:0] stat_sum;
  logic [7:0]  stat_max, rep_data;
  logic [2:0]  stat_max_idx, rep_idx;
`ifdef CONV_COLLECT_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  conv_result_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .stat_valid   (stat_valid),
    .stat_ready   (stat_ready),
    .stat_sum     (stat_sum),
    .stat_max     (stat_max),
    .stat_max_idx (stat_max_idx),
    .rep_valid    (rep_valid),
    .rep_ready    (rep_ready),
    .rep_data     (rep_data),
    .rep_idx      (rep_idx),
    .busy         (busy),
    .err_short    (err_short),
`ifdef CONV_COLLECT_DROP_CNT_EN
    .drop_cnt     (drop_cnt),
`endif
    .drop         (drop)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  function automatic void check(string name, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  int m_fill[$];      // samples of the burst being collected
  int m_held[7];      // completed burst
  bit m_stat;         // statistics waiting for acceptance
  int m_rp;           // replay pointer, -1 when not replaying
  bit m_err, m_drop;
  int m_dcnt;

  // observation logs, consumed by the directed checks
  int obs_stat[$];
  int obs_rep_d[$];
  int obs_rep_i[$];
  int n_err = 0;
  int n_drop = 0;

  function automatic int held_sum();
    int s = 0;
    foreach (m_held[i]) s += m_held[i];
    return s;
  endfunction

  function automatic int held_max_idx();
    int k = 0;
    foreach (m_held[i]) if (m_held[i] > m_held[k]) k = i;
    return k;
  endfunction

  function automatic void model_reset();
    m_fill.delete();
    m_stat = 0;
    m_rp   = -1;
    m_err  = 0;
    m_drop = 0;
    m_dcnt = 0;
  endfunction

  // Advance the model across the next rising edge using the current inputs
  function automatic void model_step();
    bit e = 0, d = 0;
    if (m_stat) begin
      d = in_valid;
      if (stat_ready) begin m_stat = 0; m_rp = 0; end
    end else if (m_rp >= 0) begin
      d = in_valid;
      if (rep_ready) begin
        m_rp++;
        if (m_rp == 7) m_rp = -1;
      end
    end else if (m_fill.size() > 0 && !in_valid) begin
      e = 1;
      m_fill.delete();
    end else if (in_valid) begin
      m_fill.push_back(int'(in_data));
      if (m_fill.size() == 7) begin
        foreach (m_held[i]) m_held[i] = m_fill[i];
        m_fill.delete();
        m_stat = 1;
      end
    end
    m_err  = e;
    m_drop = d;
    if ((e || d) && m_dcnt < 65535) m_dcnt++;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    check("stat_valid", stat_valid, int'(m_stat));
    check("stat_sum", stat_sum, m_stat ? held_sum() : 0);
    check("stat_max", stat_max, m_stat ? m_held[held_max_idx()] : 0);
    check("stat_max_idx", stat_max_idx, m_stat ? held_max_idx() : 0);
    check("rep_valid", rep_valid, int'(m_rp >= 0));
    check("rep_data", rep_data, (m_rp >= 0) ? m_held[m_rp] : 0);
    check("rep_idx", rep_idx, (m_rp >= 0) ? m_rp : 0);
    check("busy", busy, int'(m_stat || m_rp >= 0 || m_fill.size() > 0));
    check("err_short", err_short, int'(m_err));
    check("drop", drop, int'(m_drop));
`ifdef CONV_COLLECT_DROP_CNT_EN
    check("drop_cnt", drop_cnt, m_dcnt);
`endif
    if (stat_valid && stat_ready) begin
      obs_stat.push_back(int'(stat_sum));
      obs_stat.push_back(int'(stat_max));
      obs_stat.push_back(int'(stat_max_idx));
    end
    if (rep_valid && rep_ready) begin
      obs_rep_d.push_back(int'(rep_data));
      obs_rep_i.push_back(int'(rep_idx));
    end
    if (err_short) n_err++;
    if (drop) n_drop++;
    if (rst_n) model_step();
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v[7], input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = v[i][7:0];
      step();
    end
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic expect_stat(input int s, input int m, input int mi);
    check("stat_log_len", (obs_stat.size() >= 3) ? 3 : obs_stat.size(), 3);
    if (obs_stat.size() >= 3) begin
      check("lit_sum", obs_stat.pop_front(), s);
      check("lit_max", obs_stat.pop_front(), m);
      check("lit_max_idx", obs_stat.pop_front(), mi);
    end
  endtask

  task automatic expect_rep(input int v[7], input int n);
    check("rep_log_len", obs_rep_d.size(), n);
    for (int i = 0; i < n; i++) begin
      if (obs_rep_d.size() > 0) begin
        check("lit_rep_data", obs_rep_d.pop_front(), v[i]);
        check("lit_rep_idx", obs_rep_i.pop_front(), i);
      end
    end
    obs_rep_d.delete();
    obs_rep_i.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0;
`ifdef CONV_COLLECT_DROP_CNT_EN
    int c0;
`endif
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Triangle burst from the engine, consumer always ready
    stat_ready = 1'b1; rep_ready = 1'b1;
    send('{1, 2, 3, 4, 3, 2, 1}, 7);
    check("lat_stat_valid", stat_valid, 1);
    repeat (12) step();
    expect_stat(16, 4, 3);
    expect_rep('{1, 2, 3, 4, 3, 2, 1}, 7);
    check("idle_after_drain", busy, 0);

    // Ties keep first index; full-scale sum does not overflow
    send('{5, 5, 5, 5, 5, 5, 5}, 7);
    repeat (12) step();
    expect_stat(35, 5, 0);
    expect_rep('{5, 5, 5, 5, 5, 5, 5}, 7);
    send('{255, 255, 255, 255, 255, 255, 255}, 7);
    repeat (12) step();
    expect_stat(1785, 255, 0);
    expect_rep('{255, 255, 255, 255, 255, 255, 255}, 7);

    // Backpressure on both channels
    stat_ready = 1'b0; rep_ready = 1'b0;
    send('{3, 9, 2, 9, 7, 1, 4}, 7);
    repeat (5) step();
    check("held_stat_sum", stat_sum, 35);
    check("held_stat_idx", stat_max_idx, 1);
    stat_ready = 1'b1;
    step();
    stat_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rep_ready = (i % 2 == 0);
      step();
    end
    rep_ready = 1'b1;
    repeat (4) step();
    expect_stat(35, 9, 1);
    expect_rep('{3, 9, 2, 9, 7, 1, 4}, 7);

    // Short burst then a clean burst
    stat_ready = 1'b1; rep_ready = 1'b1;
    e0 = n_err;
    send('{1, 2, 3, 4, 0, 0, 0}, 4);
    step();
    check("short_err_pulse", err_short, 1);
    check("short_busy_low", busy, 0);
    step();
    check("short_err_single", err_short, 0);
    repeat (2) step();
    check("short_err_count", n_err - e0, 1);
    send('{0, 0, 0, 9, 0, 0, 0}, 7);
    repeat (12) step();
    expect_stat(9, 9, 3);
    expect_rep('{0, 0, 0, 9, 0, 0, 0}, 7);

    // Beats arriving while a burst is held in replay are dropped
    stat_ready = 1'b1; rep_ready = 1'b0;
    d0 = n_drop;
    send('{8, 6, 7, 5, 3, 0, 9}, 7);
    repeat (2) step();
`ifdef CONV_COLLECT_DROP_CNT_EN
    c0 = int'(drop_cnt);
`endif
    send('{1, 2, 3, 4, 5, 6, 7}, 7);
    repeat (2) step();
    check("drop_count", n_drop - d0, 7);
`ifdef CONV_COLLECT_DROP_CNT_EN
    check("drop_cnt_delta", int'(drop_cnt) - c0, 7);
`endif
    rep_ready = 1'b1;
    repeat (10) step();
    expect_stat(38, 9, 6);
    expect_rep('{8, 6, 7, 5, 3, 0, 9}, 7);

    // Reset in the middle of replay
    stat_ready = 1'b1; rep_ready = 1'b0;
    send('{1, 2, 3, 4, 5, 6, 7}, 7);
    step();
    rep_ready = 1'b1;
    repeat (3) step();
    rep_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rep_valid", rep_valid, 0);
    check("rst_rep_data", rep_data, 0);
    check("rst_rep_idx", rep_idx, 0);
    check("rst_stat_valid", stat_valid, 0);
    check("rst_stat_sum", stat_sum, 0);
`ifdef CONV_COLLECT_DROP_CNT_EN
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    expect_stat(28, 7, 6);
    expect_rep('{1, 2, 3, 0, 0, 0, 0}, 3);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    stat_ready = 1'b1; rep_ready = 1'b1;
    send('{2, 4, 6, 8, 10, 12, 14}, 7);
    repeat (12) step();
    expect_stat(56, 14, 6);
    expect_rep('{2, 4, 6, 8, 10, 12, 14}, 7);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
